// File: rtl/lbr_write_ctrl.sv
// Write controller for the LBR register file: accepts retired-branch events,
// advances the circular top-of-stack pointer and drives the three file write
// ports (FROM record, TO record, TOS mirror). Also handles type filtering,
// freeze and the multi-cycle hardware clear sequence.
module lbr_write_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int LBR_SIZE    = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          br_valid,
    output logic                          br_ready,
    input  logic [DATA_WIDTH-1:0]         br_from,
    input  logic [DATA_WIDTH-1:0]         br_to,
    input  logic [2:0]                    br_type,
    input  logic [7:0]                    filter_mask,
    input  logic                          lbr_enable,
    input  logic                          freeze,
    input  logic                          clear_req,
    output logic                          wEn0,
    output logic                          wEn1,
    output logic                          wEn2,
    output logic [$clog2(LBR_SIZE)+1:0]   write_sel0,
    output logic [$clog2(LBR_SIZE)+1:0]   write_sel1,
    output logic [$clog2(LBR_SIZE)+1:0]   write_sel2,
    output logic [DATA_WIDTH-1:0]         write_data0,
    output logic [DATA_WIDTH-1:0]         write_data1,
    output logic [DATA_WIDTH-1:0]         write_data2,
    output logic [$clog2(LBR_SIZE)-1:0]   tos,
    output logic                          busy,
    output logic [COUNT_WIDTH-1:0]        record_count
);
    localparam int TW = $clog2(LBR_SIZE);
    localparam int AW = TW + 2;
    localparam logic [TW-1:0] TOS_LAST = TW'(LBR_SIZE - 1);
    // LBR_SIZE is a power of two, so the region base is just the upper two bits
    localparam logic [AW-1:0] TOS_ADDR = {2'b10, {TW{1'b0}}};

    typedef enum logic [1:0] {ST_RUN, ST_FROZEN, ST_CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tos_q, tos_d;
    logic [TW-1:0]          idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [2:0]             wen_q, wen_d;
    logic [AW-1:0]          sel0_q, sel0_d, sel1_q, sel1_d, sel2_q, sel2_d;
    logic [DATA_WIDTH-1:0]  data0_q, data0_d, data1_q, data1_d, data2_q, data2_d;
    logic [TW-1:0]          t_next;
    logic [TW-1:0]          clr_at;
    logic                   do_rec;
    logic                   do_clr;

    assign br_ready = (state_q == ST_RUN) && !freeze && !clear_req;
    assign t_next   = tos_q + TW'(1);

    // Next-state, record and clear-sweep write generation
    always_comb begin
        state_d = state_q;
        tos_d   = tos_q;
        idx_d   = idx_q;
        count_d = count_q;
        wen_d   = 3'b000;
        sel0_d  = sel0_q;
        sel1_d  = sel1_q;
        sel2_d  = sel2_q;
        data0_d = data0_q;
        data1_d = data1_q;
        data2_d = data2_q;
        do_rec  = 1'b0;
        do_clr  = 1'b0;
        clr_at  = '0;

        case (state_q)
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    do_clr  = 1'b1;
                end else begin
                    if (freeze) state_d = ST_FROZEN;
                    do_rec = br_valid && br_ready && lbr_enable && !filter_mask[br_type];
                end
            end
            ST_FROZEN: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    do_clr  = 1'b1;
                end else if (!freeze) begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAR: begin
                if (idx_q == TOS_LAST) begin
                    state_d = freeze ? ST_FROZEN : ST_RUN;
                    idx_d   = '0;
                    tos_d   = TOS_LAST;
                    count_d = '0;
                end else begin
                    idx_d  = idx_q + TW'(1);
                    clr_at = idx_q + TW'(1);
                    do_clr = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (do_rec) begin
            wen_d   = 3'b111;
            sel0_d  = {2'b00, t_next};
            sel1_d  = {2'b01, t_next};
            sel2_d  = TOS_ADDR;
            data0_d = br_from;
            data1_d = br_to;
            data2_d = DATA_WIDTH'(t_next);
            tos_d   = t_next;
            if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
        end

        // Outputs are registered, so the write for index clr_at lands in the
        // same cycle that idx_q shows clr_at and busy is high
        if (do_clr) begin
            wen_d[0] = 1'b1;
            wen_d[1] = 1'b1;
            sel0_d   = {2'b00, clr_at};
            sel1_d   = {2'b01, clr_at};
            data0_d  = '0;
            data1_d  = '0;
            if (clr_at == TOS_LAST) begin
                wen_d[2] = 1'b1;
                sel2_d   = TOS_ADDR;
                data2_d  = DATA_WIDTH'(TOS_LAST);
            end
        end
    end

    // State and registered write-port outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            tos_q   <= TOS_LAST;
            idx_q   <= '0;
            count_q <= '0;
            wen_q   <= 3'b000;
            sel0_q  <= '0;
            sel1_q  <= '0;
            sel2_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign wEn0         = wen_q[0];
    assign wEn1         = wen_q[1];
    assign wEn2         = wen_q[2];
    assign write_sel0   = sel0_q;
    assign write_sel1   = sel1_q;
    assign write_sel2   = sel2_q;
    assign write_data0  = data0_q;
    assign write_data1  = data1_q;
    assign write_data2  = data2_q;
    assign tos          = tos_q;
    assign busy         = (state_q == ST_CLEAR);
    assign record_count = count_q;

endmodule

// File: tb/tb_lbr_write_ctrl.sv
// Testbench for lbr_write_ctrl: directed scenarios plus randomized traffic
// checked against an address-level behavioural model of the LBR file writes.
module tb_lbr_write_ctrl;
    localparam int L  = 16;
    localparam int DW = 32;
    localparam int CW = 5;
    localparam int TW = 4;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          br_valid = 1'b0;
    logic          br_ready;
    logic [DW-1:0] br_from = '0;
    logic [DW-1:0] br_to = '0;
    logic [2:0]    br_type = '0;
    logic [7:0]    filter_mask = '0;
    logic          lbr_enable = 1'b1;
    logic          freeze = 1'b0;
    logic          clear_req = 1'b0;
    logic          wEn0, wEn1, wEn2;
    logic [AW-1:0] write_sel0, write_sel1, write_sel2;
    logic [DW-1:0] write_data0, write_data1, write_data2;
    logic [TW-1:0] tos;
    logic          busy;
    logic [CW-1:0] record_count;

    lbr_write_ctrl #(.DATA_WIDTH(DW), .LBR_SIZE(L), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
        .br_from(br_from), .br_to(br_to), .br_type(br_type),
        .filter_mask(filter_mask), .lbr_enable(lbr_enable), .freeze(freeze),
        .clear_req(clear_req), .wEn0(wEn0), .wEn1(wEn1), .wEn2(wEn2),
        .write_sel0(write_sel0), .write_sel1(write_sel1), .write_sel2(write_sel2),
        .write_data0(write_data0), .write_data1(write_data1), .write_data2(write_data2),
        .tos(tos), .busy(busy), .record_count(record_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0 = run, 1 = frozen, 2 = clearing
    int            m_mode = 0;
    int            m_k = 0;
    int            m_tos = L - 1;
    int            m_cnt = 0;
    logic [2:0]    e_wen = '0;
    logic [AW-1:0] e_sel [3];
    logic [DW-1:0] e_data [3];
    logic [DW-1:0] ref_file [0:2*L];
    logic [DW-1:0] dut_file [0:2*L];

    logic          rdy_obs, rdy_exp;
    logic [126:0]  obs, expv;

    // A write to file address addr goes out on the port owning that region
    task automatic m_write(input int addr, input logic [DW-1:0] v);
        int p;
        p = (addr < L) ? 0 : ((addr < 2*L) ? 1 : 2);
        e_wen[p]  = 1'b1;
        e_sel[p]  = AW'(addr);
        e_data[p] = v;
        ref_file[addr] = v;
    endtask

    // Model reaction to one clock edge with the inputs currently applied
    task automatic m_clock();
        logic rdy;
        int t;
        rdy   = (m_mode == 0) && !freeze && !clear_req;
        e_wen = '0;
        if (reset) begin
            m_mode = 0; m_k = 0; m_tos = L - 1; m_cnt = 0;
            for (int p = 0; p < 3; p++) begin e_sel[p] = '0; e_data[p] = '0; end
        end else if (m_mode == 2) begin
            if (m_k == L - 1) begin
                m_mode = freeze ? 1 : 0; m_tos = L - 1; m_cnt = 0;
            end else begin
                m_k++;
                m_write(m_k, '0);
                m_write(L + m_k, '0);
                if (m_k == L - 1) m_write(2*L, DW'(L - 1));
            end
        end else if (clear_req) begin
            m_mode = 2; m_k = 0;
            m_write(0, '0);
            m_write(L, '0);
        end else begin
            if (br_valid && rdy && lbr_enable && !filter_mask[br_type]) begin
                t = (m_tos + 1) % L;
                m_write(t, br_from);
                m_write(L + t, br_to);
                m_write(2*L, DW'(t));
                m_tos = t;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
            m_mode = freeze ? 1 : 0;
        end
    endtask

    // One clock: sample ready, advance model and DUT, capture outputs
    task automatic step();
        #1;
        rdy_obs = br_ready;
        rdy_exp = (m_mode == 0) && !freeze && !clear_req;
        m_clock();
        @(posedge clock);
        #1;
        obs  = {wEn0, wEn1, wEn2, write_sel0, write_sel1, write_sel2,
                write_data0, write_data1, write_data2, tos, record_count, busy};
        expv = {e_wen[0], e_wen[1], e_wen[2], e_sel[0], e_sel[1], e_sel[2],
                e_data[0], e_data[1], e_data[2], TW'(m_tos), CW'(m_cnt), (m_mode == 2)};
        if (wEn0) dut_file[write_sel0] = write_data0;
        if (wEn1) dut_file[write_sel1] = write_data1;
        if (wEn2) dut_file[write_sel2] = write_data2;
    endtask

    task automatic idle_inputs();
        br_valid = 1'b0; br_type = '0; filter_mask = '0; lbr_enable = 1'b1;
        freeze = 1'b0; clear_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic set_event(input logic [DW-1:0] f, input logic [DW-1:0] t, input logic [2:0] ty);
        br_valid = 1'b1; br_from = f; br_to = t; br_type = ty;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        br_valid = 1'b1; br_from = 32'h1234; br_to = 32'h5678;
        step();
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL reset_model: got %h want %h", obs, expv); end
        total++;
        if ({wEn0, wEn1, wEn2, write_sel0, write_sel2, write_data0, write_data2} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %b%b%b %h %h nonzero", wEn0, wEn1, wEn2, write_sel0, write_data0);
        end
        total++;
        if ({tos, record_count, busy} !== {4'd15, 5'd0, 1'b0}) begin
            bad++; $display("FAIL reset_state: got tos=%0d cnt=%0d busy=%0d want 15 0 0", tos, record_count, busy);
        end
        reset = 1'b0; br_valid = 1'b0;
        #1;
        total++;
        if (br_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", br_ready); end
    endtask

    task automatic test_three_events();
        logic [DW-1:0] fr [3];
        logic [DW-1:0] to [3];
        fr[0] = 32'h100; fr[1] = 32'h104; fr[2] = 32'h108;
        to[0] = 32'h200; to[1] = 32'h300; to[2] = 32'h400;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_event(fr[i], to[i], 3'd0);
            step();
            total++;
            if ({rdy_obs, wEn0, wEn1, wEn2, write_sel0, write_sel1, write_sel2, write_data0, write_data1, write_data2}
                !== {1'b1, 3'b111, 6'(i), 6'(16 + i), 6'd32, fr[i], to[i], 32'(i)}) begin
                bad++;
                $display("FAIL three_ev%0d: got rdy=%b wen=%b%b%b sel=%0d/%0d/%0d d=%h/%h/%h want sels %0d/%0d/32 d2=%0d",
                         i, rdy_obs, wEn0, wEn1, wEn2, write_sel0, write_sel1, write_sel2,
                         write_data0, write_data1, write_data2, i, 16 + i, i);
            end
        end
        br_valid = 1'b0;
        step();
        total++;
        if ({wEn0, wEn1, wEn2, write_sel0, tos, record_count} !== {3'b000, 6'd2, 4'd2, 5'd3}) begin
            bad++; $display("FAIL three_after: got wen=%b%b%b sel0=%0d tos=%0d cnt=%0d want 000 2 2 3",
                            wEn0, wEn1, wEn2, write_sel0, tos, record_count);
        end
        total++;
        if (obs !== expv) begin bad++; $display("FAIL three_model: got %h want %h", obs, expv); end
    endtask

    task automatic test_back_to_back();
        int rdy_bad;
        int mdl_bad;
        rdy_bad = 0; mdl_bad = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_event($urandom, $urandom, 3'($urandom_range(0, 7)));
            step();
            if (rdy_obs !== 1'b1) rdy_bad++;
            if (obs !== expv) mdl_bad++;
        end
        br_valid = 1'b0;
        total++;
        if (rdy_bad != 0) begin bad++; $display("FAIL b2b_ready: got %0d low cycles want 0", rdy_bad); end
        total++;
        if (mdl_bad != 0) begin bad++; $display("FAIL b2b_model: got %0d mismatching cycles want 0", mdl_bad); end
        total++;
        if ({wEn0, write_sel0, write_sel1, write_data2, tos, record_count}
            !== {1'b1, 6'd0, 6'd16, 32'd0, 4'd0, 5'd17}) begin
            bad++; $display("FAIL b2b_wrap: got wen0=%b sel0=%0d sel1=%0d d2=%0d tos=%0d cnt=%0d want 1 0 16 0 0 17",
                            wEn0, write_sel0, write_sel1, write_data2, tos, record_count);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            set_event($urandom, $urandom, 3'd1);
            step();
        end
        br_valid = 1'b0;
        total++;
        if (record_count !== 5'd31) begin bad++; $display("FAIL saturate: got %0d want 31", record_count); end
        total++;
        if (tos !== 4'(39 % L)) begin bad++; $display("FAIL saturate_tos: got %0d want %0d", tos, 39 % L); end
    endtask

    task automatic test_filter();
        do_reset();
        filter_mask = 8'h04;
        set_event(32'hA0, 32'hB0, 3'd2);
        step();
        total++;
        if ({rdy_obs, wEn0, wEn1, wEn2, tos} !== {1'b1, 3'b000, 4'd15}) begin
            bad++; $display("FAIL filter_drop: got rdy=%b wen=%b%b%b tos=%0d want 1 000 15", rdy_obs, wEn0, wEn1, wEn2, tos);
        end
        set_event(32'hA4, 32'hB4, 3'd3);
        step();
        total++;
        if ({wEn0, wEn1, wEn2, write_data0, tos, record_count} !== {3'b111, 32'hA4, 4'd0, 5'd1}) begin
            bad++; $display("FAIL filter_keep: got wen=%b%b%b d0=%h tos=%0d cnt=%0d want 111 a4 0 1",
                            wEn0, wEn1, wEn2, write_data0, tos, record_count);
        end
        lbr_enable = 1'b0; filter_mask = 8'h00;
        set_event(32'hA8, 32'hB8, 3'd3);
        step();
        total++;
        if ({rdy_obs, wEn0, wEn1, wEn2, tos} !== {1'b1, 3'b000, 4'd0}) begin
            bad++; $display("FAIL disable_drop: got rdy=%b wen=%b%b%b tos=%0d want 1 000 0", rdy_obs, wEn0, wEn1, wEn2, tos);
        end
        lbr_enable = 1'b1; br_valid = 1'b0;
    endtask

    task automatic test_freeze();
        int leak;
        leak = 0;
        do_reset();
        set_event(32'hC0, 32'hD0, 3'd0);
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({rdy_obs, wEn0, wEn1, wEn2} !== 4'b0000) leak++;
        end
        total++;
        if (leak != 0) begin bad++; $display("FAIL freeze_hold: got %0d active cycles want 0", leak); end
        freeze = 1'b0;
        step();
        total++;
        if ({rdy_obs, wEn0, busy} !== 3'b000) begin
            bad++; $display("FAIL freeze_exit: got rdy=%b wen0=%b busy=%b want 000", rdy_obs, wEn0, busy);
        end
        step();
        br_valid = 1'b0;
        total++;
        if ({rdy_obs, wEn0, wEn1, wEn2, write_sel0, write_data0} !== {1'b1, 3'b111, 6'd0, 32'hC0}) begin
            bad++; $display("FAIL freeze_resume: got rdy=%b wen=%b%b%b sel0=%0d d0=%h want 1 111 0 c0",
                            rdy_obs, wEn0, wEn1, wEn2, write_sel0, write_data0);
        end
        total++;
        if (obs !== expv) begin bad++; $display("FAIL freeze_model: got %h want %h", obs, expv); end
    endtask

    task automatic test_clear();
        int busy_n, zero_w, guard, nz, mdl_bad;
        do_reset();
        for (int a = 0; a <= 2*L; a++) dut_file[a] = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            set_event($urandom | 32'h1, $urandom | 32'h1, 3'd0);
            step();
        end
        br_valid = 1'b0;
        clear_req = 1'b1;
        step();
        busy_n = busy ? 1 : 0;
        zero_w = (wEn0 && write_data0 == '0 ? 1 : 0) + (wEn1 && write_data1 == '0 ? 1 : 0);
        guard = 0; mdl_bad = (obs !== expv) ? 1 : 0;
        while (busy && guard < 40) begin
            clear_req = (busy_n == 5);
            br_valid  = 1'b1;
            step();
            guard++;
            if (obs !== expv) mdl_bad++;
            if (busy) busy_n++;
            zero_w += (wEn0 && write_data0 == '0 ? 1 : 0) + (wEn1 && write_data1 == '0 ? 1 : 0);
        end
        clear_req = 1'b0; br_valid = 1'b0;
        nz = 0;
        for (int a = 0; a < 2*L; a++) if (dut_file[a] !== '0) nz++;
        total++;
        if (busy_n != 16) begin bad++; $display("FAIL clear_busy_len: got %0d want 16", busy_n); end
        total++;
        if (zero_w != 32) begin bad++; $display("FAIL clear_zero_writes: got %0d want 32", zero_w); end
        total++;
        if (nz != 0) begin bad++; $display("FAIL clear_file: got %0d nonzero entries want 0", nz); end
        total++;
        if (dut_file[2*L] !== 32'd15) begin bad++; $display("FAIL clear_tos_write: got %0d want 15", dut_file[2*L]); end
        total++;
        if ({busy, tos, record_count} !== {1'b0, 4'd15, 5'd0}) begin
            bad++; $display("FAIL clear_final: got busy=%b tos=%0d cnt=%0d want 0 15 0", busy, tos, record_count);
        end
        total++;
        if (mdl_bad != 0) begin bad++; $display("FAIL clear_model: got %0d mismatching cycles want 0", mdl_bad); end
    endtask

    task automatic test_reset_in_clear();
        int guard;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_event($urandom, $urandom, 3'd0);
            step();
        end
        br_valid = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        guard = 0;
        while (!(busy && write_sel0 == 6'd7) && guard < 30) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 30) begin bad++; $display("FAIL rst_clear_reach: got no clear cycle 7 within %0d cycles", guard); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({busy, wEn0, wEn1, wEn2, tos, record_count} !== {1'b0, 3'b000, 4'd15, 5'd0}) begin
            bad++; $display("FAIL rst_clear_state: got busy=%b wen=%b%b%b tos=%0d cnt=%0d want 0 000 15 0",
                            busy, wEn0, wEn1, wEn2, tos, record_count);
        end
        #1;
        total++;
        if (br_ready !== 1'b1) begin bad++; $display("FAIL rst_clear_ready: got %b want 1", br_ready); end
    endtask

    task automatic test_random();
        int mdl_bad, rdy_bad;
        mdl_bad = 0; rdy_bad = 0;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            reset       = ($urandom_range(0, 149) == 0);
            clear_req   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) freeze = ~freeze;
            br_valid    = ($urandom_range(0, 3) != 0);
            br_from     = $urandom;
            br_to       = $urandom;
            br_type     = 3'($urandom_range(0, 7));
            filter_mask = 8'($urandom & $urandom & $urandom);
            lbr_enable  = ($urandom_range(0, 7) != 0);
            step();
            if (rdy_obs !== rdy_exp) begin
                rdy_bad++;
                if (rdy_bad <= 5) $display("FAIL rand_ready cyc%0d: got %b want %b", i, rdy_obs, rdy_exp);
            end
            if (obs !== expv) begin
                mdl_bad++;
                if (mdl_bad <= 5) $display("FAIL rand_out cyc%0d: got %h want %h", i, obs, expv);
            end
        end
        idle_inputs();
        reset = 1'b0;
        total++;
        if (rdy_bad != 0) begin bad++; $display("FAIL rand_ready_total: got %0d bad cycles want 0", rdy_bad); end
        total++;
        if (mdl_bad != 0) begin bad++; $display("FAIL rand_out_total: got %0d bad cycles want 0", mdl_bad); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < 3; p++) begin e_sel[p] = '0; e_data[p] = '0; end
        test_reset();
        test_three_events();
        test_back_to_back();
        test_saturate();
        test_filter();
        test_freeze();
        test_clear();
        test_reset_in_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lbr_write_ctrl.md
Name: lbr_write_ctrl

Overview:
- Upstream write controller for the LBR register file.
- Takes retired-branch events from the commit stage over a valid/ready handshake.
- Maintains the circular top-of-stack (TOS) pointer.
- Drives the file's three write ports: FROM record, TO record and TOS mirror, all in one cycle.
- Also provides branch-type filtering, freeze and a multi-cycle hardware clear sequence.

Parameters:
- DATA_WIDTH, 32, width of PC values and register-file data.
- LBR_SIZE, 16, number of branch records; power of two, >=2.
- COUNT_WIDTH, 16, width of the saturating record counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- br_valid  in  1  retired-branch event valid.
- br_ready  out  1  controller accepts event this cycle.
- br_from  in  DATA_WIDTH  branch source PC.
- br_to  in  DATA_WIDTH  branch target PC.
- br_type  in  3  branch class, indexes filter_mask.
- filter_mask  in  8  bit k=1: drop events with br_type==k.
- lbr_enable  in  1  0: accept and drop all events.
- freeze  in  1  level; stall recording while high.
- clear_req  in  1  one-cycle pulse; start clear sequence.
- wEn0, wEn1, wEn2  out  1 each  write enables to the file.
- write_sel0, write_sel1, write_sel2  out  clog2(LBR_SIZE)+2 each  write addresses.
- write_data0, write_data1, write_data2  out  DATA_WIDTH each  write data.
- tos  out  clog2(LBR_SIZE)  current TOS index.
- busy  out  1  clear sequence in progress.
- record_count  out  COUNT_WIDTH  records written since reset or last clear; saturating.

Behaviour:
- Address map, with AW=clog2(LBR_SIZE)+2:
  - FROM[i] at i.
  - TO[i] at LBR_SIZE+i.
  - TOS register at 2*LBR_SIZE.
  - The file resets TOS to all-ones, i.e. LBR_SIZE-1.
- States: RUN, FROZEN, CLEAR.
- Reset (synchronous, active-high):
  - State=RUN; all wEn=0; all write_sel/write_data=0.
  - tos=LBR_SIZE-1; record_count=0; busy=0; clear index=0.
  - Reset during CLEAR aborts the sequence immediately.
- br_ready is combinational: br_ready = (state==RUN) && !freeze && !clear_req.
- Accept condition: br_valid && br_ready in cycle N.
  - If lbr_enable && !filter_mask[br_type], the event is recorded.
  - Otherwise it is consumed with no write.
- Record: registered outputs valid in cycle N+1 for exactly one cycle.
  - Let t=(tos+1) mod LBR_SIZE.
  - wEn0=1, sel0=t, data0=br_from.
  - wEn1=1, sel1=LBR_SIZE+t, data1=br_to.
  - wEn2=1, sel2=2*LBR_SIZE, data2=zero-extended t.
  - tos<=t; record_count increments, saturating at all-ones.
- Wrap-around: tos=LBR_SIZE-1 wraps to 0, overwriting the oldest record. No overflow flag.
- Back-to-back events: one record per cycle, full throughput, no bubbles.
- Every cycle with no record or clear write: all wEn=0. Sel/data hold their last values.
- Write ports never target the same address in one cycle, by construction of the address map.
- FROZEN:
  - Entered from RUN when freeze=1 (sampled); br_ready=0 while freeze is high.
  - Returns to RUN the cycle after freeze=0.
  - A record already accepted still completes its N+1 write.
- CLEAR:
  - Entered when clear_req=1 in RUN or FROZEN. Priority: clear_req > freeze > event.
  - busy=1 for LBR_SIZE cycles, idx=0..LBR_SIZE-1.
  - Each cycle: wEn0 writes 0 to FROM[idx]; wEn1 writes 0 to TO[idx].
  - Last cycle (idx=LBR_SIZE-1) also: wEn2 writes LBR_SIZE-1 to TOS; tos<=LBR_SIZE-1; record_count<=0.
  - Then RUN if freeze=0, else FROZEN.
  - clear_req while busy is ignored.
  - br_ready=0 throughout CLEAR.
- Filter/enable changes take effect for events accepted in the same cycle.

Test Plan:
- Reset, then three events (from 0x100/to 0x200, 0x104/0x300, 0x108/0x400) -> writes at sels 0/16/32, 1/17/32, 2/18/32; data2=0,1,2; tos=2; record_count=3.
- 17 back-to-back events from reset -> the 17th writes sel0=0, sel1=16, data2=0; tos wraps to 0; br_ready stays 1 every cycle.
- filter_mask=0x04, events with br_type=2 and 3 -> type 2 consumed with all wEn=0; type 3 recorded; tos advances by 1 only.
- freeze high for 5 cycles with br_valid held -> br_ready=0 and no writes; first event recorded the cycle after freeze falls.
- clear_req after 5 records -> busy=1 for 16 cycles; 32 zero writes across addresses 0..31; final cycle writes 15 to address 32; tos=15; count=0; a second clear_req mid-sequence has no effect.
- reset asserted on clear cycle 7 -> next cycle: busy=0, all wEn=0, tos=15, state RUN.
